// File: rtl/l2r_pkg.sv
// Shared encodings for the left-to-right exponentiation controller:
// state codes, C-mux selects and counter-mux selects.
package l2r_pkg;

   localparam int unsigned L2R_K = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_SQR  = 3'd2,
      ST_MUL  = 3'd3,
      ST_NEXT = 3'd4,
      ST_CHK  = 3'd5,
      ST_DONE = 3'd6
   } l2r_state_t;

   localparam logic [1:0] SC_ONE    = 2'b00;
   localparam logic [1:0] SC_SQR    = 2'b01;
   localparam logic [1:0] SC_MUL    = 2'b10;

   localparam logic       SCOUN_K   = 1'b0;
   localparam logic       SCOUN_DEC = 1'b1;

endpackage

// File: rtl/l2r_controller.sv
// Moore sequencer for the L2R exponentiation datapath (C = A^B, MSB first).
// Optional feature: define L2R_ABORT_EN to add the abort input.
module l2r_controller
   import l2r_pkg::*;
#(
   parameter int unsigned K = L2R_K
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_in,
   input  logic       equals,
   input  logic       regBk,
   output logic       LoadA,
   output logic       LoadB,
   output logic       ShiftB,
   output logic       LoadC,
   output logic       LoadCoun,
   output logic       S_Coun,
   output logic [1:0] S_C,
   output logic       busy,
   output logic       done
`ifdef L2R_ABORT_EN
   ,
   input  logic       abort
`endif
);

   // K only has to agree with the datapath width; the controller itself is width-independent.
   if (K < 1) begin : g_bad_k
      $error("l2r_controller: K must be at least 1");
   end

   l2r_state_t state, state_nxt;
   logic       abort_now;

`ifdef L2R_ABORT_EN
   assign abort_now = abort && busy;
`else
   assign abort_now = 1'b0;
`endif

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (start_in) state_nxt = ST_LOAD;
         ST_LOAD: state_nxt = ST_SQR;
         ST_SQR:  state_nxt = regBk ? ST_MUL : ST_NEXT;
         ST_MUL:  state_nxt = ST_NEXT;
         ST_NEXT: state_nxt = ST_CHK;
         ST_CHK:  state_nxt = equals ? ST_DONE : ST_SQR;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      if (abort_now) state_nxt = ST_IDLE;
   end

   assign busy = (state != ST_IDLE) && (state != ST_DONE);

   always_comb begin
      LoadA    = 1'b0;
      LoadB    = 1'b0;
      ShiftB   = 1'b0;
      LoadC    = 1'b0;
      LoadCoun = 1'b0;
      S_Coun   = SCOUN_K;
      S_C      = SC_ONE;
      done     = 1'b0;
      unique case (state)
         ST_LOAD: begin
            LoadA    = 1'b1;
            LoadB    = 1'b1;
            LoadC    = 1'b1;
            LoadCoun = 1'b1;
         end
         ST_SQR: begin
            LoadC = 1'b1;
            S_C   = SC_SQR;
         end
         ST_MUL: begin
            LoadC = 1'b1;
            S_C   = SC_MUL;
         end
         ST_NEXT: begin
            ShiftB   = 1'b1;
            LoadCoun = 1'b1;
            S_Coun   = SCOUN_DEC;
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
      // An abort must not let the datapath commit anything in the cycle it is raised.
      if (abort_now) begin
         LoadA    = 1'b0;
         LoadB    = 1'b0;
         ShiftB   = 1'b0;
         LoadC    = 1'b0;
         LoadCoun = 1'b0;
         S_Coun   = SCOUN_K;
         S_C      = SC_ONE;
      end
   end

endmodule

// File: tb/tb_l2r_controller.sv
// Bench for l2r_controller: a behavioural datapath closes the loop, and results are
// compared with plain-arithmetic powers and the cycle count implied by the exponent.
module tb_l2r_controller;
   import l2r_pkg::*;

   localparam int K = 16;

   logic       clk = 1'b0;
   logic       rst, start_in, equals, regBk;
   logic       LoadA, LoadB, ShiftB, LoadC, LoadCoun, S_Coun, busy, done;
   logic [1:0] S_C;
`ifdef L2R_ABORT_EN
   logic       abort;
`endif

   int checks = 0;
   int errors = 0;

   logic [15:0] op_a, op_b;
   logic [15:0] a_reg, b_reg, c_reg;
   logic [4:0]  cnt;

   always #5 clk = ~clk;

   l2r_controller #(.K(K)) dut (
      .clk(clk), .rst(rst), .start_in(start_in), .equals(equals), .regBk(regBk),
      .LoadA(LoadA), .LoadB(LoadB), .ShiftB(ShiftB), .LoadC(LoadC), .LoadCoun(LoadCoun),
      .S_Coun(S_Coun), .S_C(S_C), .busy(busy), .done(done)
`ifdef L2R_ABORT_EN
      , .abort(abort)
`endif
   );

   // Behavioural L2Rdatapath
   always_ff @(posedge clk) begin
      if (!rst) begin
         a_reg <= '0;
         b_reg <= '0;
         c_reg <= '0;
         cnt   <= 5'(K + 1);
      end else begin
         if (LoadA) a_reg <= op_a;
         if (LoadB) b_reg <= op_b;
         else if (ShiftB) b_reg <= b_reg << 1;
         if (LoadC) begin
            case (S_C)
               2'b00:   c_reg <= 16'd1;
               2'b01:   c_reg <= c_reg * c_reg;
               2'b10:   c_reg <= c_reg * a_reg;
               default: c_reg <= c_reg;
            endcase
         end
         if (LoadCoun) cnt <= S_Coun ? cnt - 5'd1 : 5'(K);
      end
   end
   assign equals = (cnt == 5'd0);
   assign regBk  = b_reg[15];

   function automatic logic [15:0] ref_pow(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] acc;
      acc = 16'd1;
      for (int i = 0; i < int'(b); i++) acc = acc * a;
      return acc;
   endfunction

   function automatic logic [9:0] outs();
      return {LoadA, LoadB, ShiftB, LoadC, LoadCoun, S_Coun, S_C, busy, done};
   endfunction

   // One complete operation with checks on LOAD strobes, latency, MUL count, result and return to IDLE.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit noise);
      int busy_cnt = 0, mul_cnt = 0, exp_lat;
      bit got_done = 0;
      exp_lat = 1 + 3 * K + $countones(b);
      @(negedge clk);
      op_a = a; op_b = b; start_in = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
      checks++;
      if (outs() !== 10'b11011_0_00_1_0) begin
         errors++;
         $display("FAIL load_strobes a=%0d b=%h got %b want %b", a, b, outs(), 10'b1101100010);
      end
      for (int i = 0; i < 300 && !got_done; i++) begin
         if (done) got_done = 1;
         else begin
            if (busy) busy_cnt++;
            if (LoadC && S_C == SC_MUL) mul_cnt++;
            if (noise) start_in = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
      end
      start_in = 1'b0;
      checks++;
      if (!got_done) begin
         errors++;
         $display("FAIL done_timeout a=%0d b=%h got no done want done", a, b);
      end else begin
         checks++;
         if (busy_cnt != exp_lat) begin
            errors++;
            $display("FAIL latency a=%0d b=%h got %0d want %0d", a, b, busy_cnt, exp_lat);
         end
         checks++;
         if (mul_cnt != $countones(b)) begin
            errors++;
            $display("FAIL mul_count b=%h got %0d want %0d", b, mul_cnt, $countones(b));
         end
         checks++;
         if (c_reg !== ref_pow(a, b)) begin
            errors++;
            $display("FAIL result a=%0d b=%h got %0d want %0d", a, b, c_reg, ref_pow(a, b));
         end
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_done got %b want 0", busy);
         end
         for (int j = 0; j < (noise ? 3 : 1); j++) begin
            @(negedge clk);
            checks++;
            if (outs() !== 10'd0) begin
               errors++;
               $display("FAIL idle_after_done cycle %0d got %b want 0", j, outs());
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start_in = 1'b1; op_a = 0; op_b = 0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (outs() !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0", outs());
         end
      end
      start_in = 1'b0; rst = 1'b1;
      @(negedge clk);
      checks++;
      if (outs() !== 10'd0) begin
         errors++;
         $display("FAIL idle_after_reset got %b want 0", outs());
      end
   endtask

   task automatic test_directed();
      run_op(16'd3, 16'd0, 0);
      run_op(16'd3, 16'd5, 0);
      run_op(16'd2, 16'hFFFF, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++)
         run_op(16'($urandom), 16'($urandom), 0);
   endtask

   task automatic test_busy_start();
      run_op(16'd7, 16'h00A3, 1);
      run_op(16'($urandom), 16'($urandom), 1);
   endtask

   task automatic test_back_to_back();
      int dones = 0;
      int last_done = -1;
      op_a = 16'd5; op_b = 16'd3;
      @(negedge clk);
      start_in = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (done) begin
            checks++;
            if (c_reg !== ref_pow(16'd5, 16'd3)) begin
               errors++;
               $display("FAIL held_result got %0d want %0d", c_reg, ref_pow(16'd5, 16'd3));
            end
            if (last_done >= 0) begin
               checks++;
               if (t - last_done != 1 + 3 * K + 2 + 2) begin
                  errors++;
                  $display("FAIL done_spacing got %0d want %0d", t - last_done, 1 + 3 * K + 4);
               end
            end
            last_done = t;
            dones++;
         end
      end
      start_in = 1'b0;
      checks++;
      if (dones < 3) begin
         errors++;
         $display("FAIL held_done_count got %0d want >=3", dones);
      end
      for (int i = 0; i < 100 && (busy || done); i++) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int dones = 0;
      @(negedge clk);
      op_a = 16'd3; op_b = 16'd5; start_in = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
      repeat (19) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      checks++;
      if (outs() !== 10'd0) begin
         errors++;
         $display("FAIL reset_mid_outputs got %b want 0", outs());
      end
      repeat (60) begin
         @(negedge clk);
         if (done || busy) dones++;
      end
      checks++;
      if (dones != 0) begin
         errors++;
         $display("FAIL reset_mid_activity got %0d cycles want 0", dones);
      end
      run_op(16'd3, 16'd5, 0);
   endtask

`ifdef L2R_ABORT_EN
   task automatic test_abort();
      @(negedge clk);
      op_a = 16'd3; op_b = 16'd5; start_in = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
      repeat (9) @(negedge clk);
      abort = 1'b1;
      #1;
      checks++;
      if (outs() & 10'b11111_1_11_0_1) begin
         errors++;
         $display("FAIL abort_strobes got %b want no strobes", outs());
      end
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (outs() !== 10'd0) begin
         errors++;
         $display("FAIL abort_idle got %b want 0", outs());
      end
      run_op(16'd7, 16'd2, 0);
   endtask
`endif

   initial begin
`ifdef L2R_ABORT_EN
      abort = 1'b0;
`endif
      test_reset();
      test_directed();
      test_random();
      test_busy_start();
      test_back_to_back();
      test_reset_mid();
`ifdef L2R_ABORT_EN
      test_abort();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
